erasure_marker: RTL and testbench

//  Downstream of the threshold computation stage. Consumes per-bit soft LLRs and the two cutoff

---
 rtl/erasure_pkg.sv | 36 +++
 rtl/llr_symbol_packer.sv | 78 +++++++
 rtl/erasure_marker.sv | 140 ++++++++++++++
 tb/tb_erasure_marker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/erasure_pkg.sv
// Shared sizes, FSM state type and LLR reliability helpers for the erasure marking stage.
package erasure_pkg;

    localparam int LLR_W     = 24;
    localparam int SYM_W     = 8;
    localparam int N_SYM     = 255;
    localparam int MAX_ERASE = 16;
    localparam int N_LVL     = 2;
    localparam int CNT_W     = $clog2(SYM_W);

    typedef enum logic [0:0] {
        WAIT_THR = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Magnitude of a signed LLR; the most-negative code maps to the largest positive value.
    function automatic logic [LLR_W-1:0] abs_sat(input logic [LLR_W-1:0] x);
        if (!x[LLR_W-1]) begin
            return x;
        end else if (x == {1'b1, {(LLR_W-1){1'b0}}}) begin
            return {1'b0, {(LLR_W-1){1'b1}}};
        end else begin
            return -x;
        end
    endfunction

    function automatic logic is_unreliable(input logic [LLR_W-1:0] llr,
                                           input logic [LLR_W-1:0] cutoff);
        logic signed [LLR_W:0] neg_mag;
        logic signed [LLR_W:0] thr_ext;
        neg_mag = -$signed({1'b0, abs_sat(llr)});
        thr_ext = $signed({cutoff[LLR_W-1], cutoff});
        return neg_mag > thr_ext;
    endfunction

endpackage

// File: rtl/llr_symbol_packer.sv
// Shifts hard decisions into RS symbols and tracks per-level sticky erasure flags.
module llr_symbol_packer
    import erasure_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          accept,
    input  logic [LLR_W-1:0]              llr,
    input  logic [N_LVL-1:0][LLR_W-1:0]   cutoff,
    output logic                          done,
    output logic [N_LVL-1:0]              done_erase,
    output logic                          sym_valid,
    output logic [SYM_W-1:0]              sym_data,
    output logic [N_LVL-1:0]              sym_erase
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

    logic [CNT_W-1:0] bit_cnt_reg;
    logic [SYM_W-2:0] shift_reg;
    logic [SYM_W-1:0] done_data;
    logic             last_bit;

    assign last_bit  = (bit_cnt_reg == LAST_BIT);
    assign done      = accept && last_bit;
    assign done_data = {shift_reg, llr[LLR_W-1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (accept) begin
            bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
            shift_reg   <= last_bit ? '0 : done_data[SYM_W-2:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LVL; gi++) begin : g_lvl
            logic unrel;
            logic sticky_reg;

            assign unrel          = is_unreliable(llr, cutoff[gi]);
            assign done_erase[gi] = sticky_reg | unrel;

            // Flag restarts with each symbol so one bad bit taints only its own symbol.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sticky_reg <= 1'b0;
                end else if (accept) begin
                    sticky_reg <= last_bit ? 1'b0 : (sticky_reg | unrel);
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sym_erase[gi] <= 1'b0;
                end else if (done) begin
                    sym_erase[gi] <= done_erase[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym_valid <= 1'b0;
            sym_data  <= '0;
        end else begin
            sym_valid <= done;
            if (done) begin
                sym_data <= done_data;
            end
        end
    end

endmodule

// File: rtl/erasure_marker.sv
// Marks RS symbols as erasures at two LLR cutoff levels and counts them per codeword.
module erasure_marker
    import erasure_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cutoff_threshold_ready,
    input  logic [LLR_W-1:0]  cutoff_threshold_0,
    input  logic [LLR_W-1:0]  cutoff_threshold_1,
    input  logic              bit_valid,
    input  logic [LLR_W-1:0]  bit_llr,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_data,
    output logic              sym_erase_0,
    output logic              sym_erase_1,
    output logic [7:0]        sym_index,
    output logic              cw_done,
    output logic [7:0]        erase_count_0,
    output logic [7:0]        erase_count_1,
    output logic              erase_overflow_0,
    output logic              erase_overflow_1
);

    localparam logic [7:0] LAST_SYM = 8'(N_SYM - 1);

    state_t                        state_reg;
    logic                          accept;
    logic                          thr_sampled_reg;
    logic [7:0]                    sym_idx_reg;
    logic                          last_sym;
    logic                          done;
    logic [N_LVL-1:0]              done_erase;
    logic [N_LVL-1:0]              sym_erase;
    logic [N_LVL-1:0][LLR_W-1:0]   live_thr;
    logic [N_LVL-1:0][LLR_W-1:0]   eff_thr;
    logic [N_LVL-1:0][7:0]         count_out;
    logic [N_LVL-1:0]              ovf_out;

    assign bit_ready   = (state_reg == RUN);
    assign accept      = bit_valid && bit_ready;
    assign last_sym    = (sym_idx_reg == LAST_SYM);
    assign live_thr[0] = cutoff_threshold_0;
    assign live_thr[1] = cutoff_threshold_1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= WAIT_THR;
        end else if (state_reg == WAIT_THR && cutoff_threshold_ready) begin
            state_reg <= RUN;
        end
    end

    // The first bit of a codeword sees the live cutoffs; the rest see the captured copy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            thr_sampled_reg <= 1'b0;
        end else if (done && last_sym) begin
            thr_sampled_reg <= 1'b0;
        end else if (accept) begin
            thr_sampled_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym_idx_reg <= '0;
            sym_index   <= '0;
            cw_done     <= 1'b0;
        end else begin
            cw_done <= done && last_sym;
            if (done) begin
                sym_index   <= sym_idx_reg;
                sym_idx_reg <= last_sym ? '0 : sym_idx_reg + 8'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LVL; gi++) begin : g_lvl
            logic [LLR_W-1:0] thr_reg;
            logic [7:0]       run_cnt_reg;
            logic [7:0]       total;
            logic [7:0]       erase_cnt_reg;
            logic             erase_ovf_reg;

            assign eff_thr[gi]   = thr_sampled_reg ? thr_reg : live_thr[gi];
            assign total         = (run_cnt_reg == 8'hFF) ? 8'hFF
                                                          : run_cnt_reg + {7'd0, done_erase[gi]};
            assign count_out[gi] = erase_cnt_reg;
            assign ovf_out[gi]   = erase_ovf_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    thr_reg <= '0;
                end else if (accept && !thr_sampled_reg) begin
                    thr_reg <= live_thr[gi];
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    run_cnt_reg   <= '0;
                    erase_cnt_reg <= '0;
                    erase_ovf_reg <= 1'b0;
                end else if (done) begin
                    if (last_sym) begin
                        run_cnt_reg   <= '0;
                        erase_cnt_reg <= total;
                        erase_ovf_reg <= (total > 8'(MAX_ERASE));
                    end else begin
                        run_cnt_reg <= total;
                    end
                end
            end
        end
    endgenerate

    llr_symbol_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .accept     (accept),
        .llr        (bit_llr),
        .cutoff     (eff_thr),
        .done       (done),
        .done_erase (done_erase),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_erase  (sym_erase)
    );

    assign sym_erase_0      = sym_erase[0];
    assign sym_erase_1      = sym_erase[1];
    assign erase_count_0    = count_out[0];
    assign erase_count_1    = count_out[1];
    assign erase_overflow_0 = ovf_out[0];
    assign erase_overflow_1 = ovf_out[1];

endmodule

// File: tb/tb_erasure_marker.sv
// Randomized bench for erasure_marker against a symbol-level reference model.
module tb_erasure_marker;

    logic        clock = 1'b0;
    logic        reset;
    logic        cutoff_threshold_ready;
    logic [23:0] cutoff_threshold_0;
    logic [23:0] cutoff_threshold_1;
    logic        bit_valid;
    logic [23:0] bit_llr;
    logic        bit_ready;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_erase_0;
    logic        sym_erase_1;
    logic [7:0]  sym_index;
    logic        cw_done;
    logic [7:0]  erase_count_0;
    logic [7:0]  erase_count_1;
    logic        erase_overflow_0;
    logic        erase_overflow_1;

    erasure_marker dut (
        .clock                  (clock),
        .reset                  (reset),
        .cutoff_threshold_ready (cutoff_threshold_ready),
        .cutoff_threshold_0     (cutoff_threshold_0),
        .cutoff_threshold_1     (cutoff_threshold_1),
        .bit_valid              (bit_valid),
        .bit_llr                (bit_llr),
        .bit_ready              (bit_ready),
        .sym_valid              (sym_valid),
        .sym_data               (sym_data),
        .sym_erase_0            (sym_erase_0),
        .sym_erase_1            (sym_erase_1),
        .sym_index              (sym_index),
        .cw_done                (cw_done),
        .erase_count_0          (erase_count_0),
        .erase_count_1          (erase_count_1),
        .erase_overflow_0       (erase_overflow_0),
        .erase_overflow_1       (erase_overflow_1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       e0, e1;
        logic [7:0] idx;
        logic       done;
        logic [7:0] c0, c1;
        logic       o0, o1;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: bits grouped into symbols, symbols into codewords of 255.
    int     m_bit, m_sym, m_byte, m_c0, m_c1;
    bit     m_e0, m_e1;
    longint m_thr0, m_thr1;

    function automatic bit unrel(longint v, longint t);
        longint a;
        a = (v < 0) ? -v : v;
        if (a > 64'sd8388607) a = 64'sd8388607;
        return (-a) > t;
    endfunction

    task automatic model_reset();
        m_bit = 0; m_sym = 0; m_byte = 0; m_c0 = 0; m_c1 = 0;
        m_e0 = 0; m_e1 = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [23:0] v);
        longint sv;
        exp_t   e;
        sv = longint'($signed(v));
        if (m_bit == 0 && m_sym == 0) begin
            m_thr0 = longint'($signed(cutoff_threshold_0));
            m_thr1 = longint'($signed(cutoff_threshold_1));
        end
        m_byte = ((m_byte << 1) | ((sv < 0) ? 1 : 0)) & 255;
        m_e0 |= unrel(sv, m_thr0);
        m_e1 |= unrel(sv, m_thr1);
        m_bit++;
        if (m_bit == 8) begin
            e.due  = cyc;
            e.data = 8'(m_byte);
            e.e0   = m_e0;
            e.e1   = m_e1;
            e.idx  = 8'(m_sym);
            e.done = (m_sym == 254);
            m_c0 = (m_c0 + m_e0 > 255) ? 255 : m_c0 + m_e0;
            m_c1 = (m_c1 + m_e1 > 255) ? 255 : m_c1 + m_e1;
            e.c0 = 8'(m_c0);
            e.c1 = 8'(m_c1);
            e.o0 = (m_c0 > 16);
            e.o1 = (m_c1 > 16);
            exp_q.push_back(e);
            if (e.done) begin
                m_c0 = 0; m_c1 = 0; m_sym = 0;
            end else begin
                m_sym++;
            end
            m_bit = 0; m_byte = 0; m_e0 = 0; m_e1 = 0;
        end
    endtask

    always @(negedge clock) begin
        bit   due_now;
        exp_t e;
        due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        if (due_now || sym_valid) begin
            check("sym_valid", 32'(sym_valid), 32'(due_now));
            if (due_now) begin
                e = exp_q.pop_front();
                $display("sym idx=%0d data=%02h e0=%0b e1=%0b done=%0b", e.idx, e.data, e.e0, e.e1, e.done);
                check("sym_data", 32'(sym_data), 32'(e.data));
                check("sym_erase_0", 32'(sym_erase_0), 32'(e.e0));
                check("sym_erase_1", 32'(sym_erase_1), 32'(e.e1));
                check("sym_index", 32'(sym_index), 32'(e.idx));
                check("cw_done", 32'(cw_done), 32'(e.done));
                if (e.done) begin
                    check("erase_count_0", 32'(erase_count_0), 32'(e.c0));
                    check("erase_count_1", 32'(erase_count_1), 32'(e.c1));
                    check("erase_overflow_0", 32'(erase_overflow_0), 32'(e.o0));
                    check("erase_overflow_1", 32'(erase_overflow_1), 32'(e.o1));
                end
            end
        end
    end

    function automatic logic [23:0] mk_llr(input longint v);
        return 24'(v);
    endfunction

    function automatic logic [23:0] rand_llr();
        longint m;
        case ($urandom_range(0, 9))
            0: return 24'h800000;
            1: return 24'h7FFFFF;
            default: begin
                m = longint'($urandom_range(0, 600));
                return $urandom_range(0, 1) ? mk_llr(-m) : mk_llr(m);
            end
        endcase
    endfunction

    task automatic send_bit(input logic [23:0] v);
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                bit_valid = 1'b0;
                bit_llr   = 24'($urandom);
                @(posedge clock); #1;
            end
        end
        bit_valid = 1'b1;
        bit_llr   = v;
        @(posedge clock); #1;
        model_accept(v);
        bit_valid = 1'b0;
    endtask

    // kind: 0 all +300, 1 {-300,+100,+300..}, 2 one +10 bit, 3 random, 4 large magnitude
    task automatic send_sym(input int kind);
        int     pos;
        longint m;
        pos = $urandom_range(0, 7);
        for (int b = 0; b < 8; b++) begin
            case (kind)
                0: send_bit(mk_llr(300));
                1: send_bit(mk_llr(b == 0 ? -300 : (b == 1 ? 100 : 300)));
                2: send_bit(mk_llr(b == pos ? 10 : 300));
                3: send_bit(rand_llr());
                default: begin
                    m = longint'($urandom_range(400, 8388607));
                    send_bit($urandom_range(0, 1) ? mk_llr(-m) : mk_llr(m));
                end
            endcase
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bit_ready"}, 32'(bit_ready), 0);
        check({tag, "_sym_data"}, 32'(sym_data), 0);
        check({tag, "_sym_erase"}, 32'({sym_erase_0, sym_erase_1}), 0);
        check({tag, "_sym_index"}, 32'(sym_index), 0);
        check({tag, "_cw_done"}, 32'(cw_done), 0);
        check({tag, "_erase_count"}, 32'({erase_count_0, erase_count_1}), 0);
        check({tag, "_overflow"}, 32'({erase_overflow_0, erase_overflow_1}), 0);
    endtask

    initial begin
        model_reset();
        reset                  = 1'b0;
        cutoff_threshold_ready = 1'b0;
        cutoff_threshold_0     = '0;
        cutoff_threshold_1     = '0;
        bit_valid              = 1'b1;
        bit_llr                = 24'h123456;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("wait_thr_bit_ready", 32'(bit_ready), 0);
        bit_valid = 1'b0;

        cutoff_threshold_0     = mk_llr(-85);
        cutoff_threshold_1     = mk_llr(-173);
        cutoff_threshold_ready = 1'b1;
        @(posedge clock); #1;
        check("run_bit_ready", 32'(bit_ready), 1);

        // Codeword A: 16 level-0 and 17 level-1 erasures; thr0 change mid-word is deferred.
        for (int s = 0; s < 255; s++) begin
            if (s == 100) cutoff_threshold_0 = mk_llr(-400);
            if (s == 0)       send_sym(0);
            else if (s == 1)  send_sym(1);
            else if (s <= 17) send_sym(2);
            else              send_sym(0);
        end

        // Codeword B: random LLRs under thr0=-400; thr1 change lands in codeword C.
        for (int s = 0; s < 255; s++) begin
            if (s == 50) cutoff_threshold_1 = mk_llr(-longint'($urandom_range(1, 399)));
            send_sym(3);
        end

        // Codeword C: every bit reliable at both levels.
        for (int s = 0; s < 255; s++) send_sym(4);

        // Codeword D interrupted by reset at bit 5 of symbol 3.
        for (int s = 0; s < 3; s++) send_sym(3);
        for (int b = 0; b < 5; b++) send_bit(rand_llr());
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_idle_outputs("midreset");
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rerun_bit_ready", 32'(bit_ready), 1);
        for (int s = 0; s < 6; s++) send_sym(3);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        check("drain_pending", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
